// File: rtl/tanh_act_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tanh_act_pkg
//  Description : Shared constants and helpers for the 4-bit tanh activation
//                feeders. The output code is offset binary, so a signed
//                pre-activation q maps to the code q + CODE_ZERO.
//  Revision    : 1.0 - initial release
// ============================================================================
package tanh_act_pkg;

    localparam int              CODE_W    = 4;
    localparam logic [3:0]      CODE_ZERO = 4'd8;
    localparam int              CODE_MIN  = -8;
    localparam int              CODE_MAX  = 7;

    // Ceiling log2, usable in constant expressions
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tanh_4bit_preact_quant.sv
`default_nettype none
// ============================================================================
//  Module      : tanh_4bit_preact_quant
//  Description : Combinational quantiser. Arithmetic right shift of the
//                accumulated sum (floor toward -inf), clamp to the signed
//                4-bit range, then convert to the offset-binary code.
//  Revision    : 1.0 - initial release
// ============================================================================
module tanh_4bit_preact_quant
    import tanh_act_pkg::*;
#(
    parameter int ACC_W = 12,
    parameter int SHIFT = 4
) (
    input  logic signed [ACC_W-1:0]  i_sum,
    output logic                     o_sat,
    output logic        [CODE_W-1:0] o_code
);

    localparam logic signed [ACC_W-1:0] c_q_max = ACC_W'(CODE_MAX);
    localparam logic signed [ACC_W-1:0] c_q_min = ACC_W'(CODE_MIN);

    logic signed [ACC_W-1:0] w_q;

    // Shift, clamp and re-bias; the 4-bit add wraps q into offset binary
    always_comb begin
        w_q    = i_sum >>> SHIFT;
        o_sat  = 1'b0;
        o_code = w_q[CODE_W-1:0] + CODE_ZERO;
        if (w_q > c_q_max) begin
            o_sat  = 1'b1;
            o_code = c_q_max[CODE_W-1:0] + CODE_ZERO;
        end else if (w_q < c_q_min) begin
            o_sat  = 1'b1;
            o_code = c_q_min[CODE_W-1:0] + CODE_ZERO;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tanh_4bit_preact_mac.sv
`default_nettype none
// ============================================================================
//  Module      : tanh_4bit_preact_mac
//  Description : Streams N_TERMS signed 4-bit x/w pairs, accumulates the
//                products and quantises each finished sum into a one-entry
//                valid/ready output slot feeding the tanh block's In[3:0].
//                The next vector accumulates while a result waits; only the
//                final term of a vector can be stalled.
//  Revision    : 1.0 - initial release
// ============================================================================
module tanh_4bit_preact_mac
    import tanh_act_pkg::*;
#(
    parameter int N_TERMS = 8,
    parameter int ACC_W   = 12,
    parameter int SHIFT   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [3:0]        x_data,
    input  logic [3:0]        w_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CODE_W-1:0] m_code,
    output logic              m_sat
);

    localparam int                 c_cnt_w    = (clog2(N_TERMS) < 1) ? 1 : clog2(N_TERMS);
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(N_TERMS - 1);

    if (N_TERMS < 2) begin : g_n_terms_check
        $error("N_TERMS must be at least 2");
    end
    if (ACC_W < 8 + clog2(N_TERMS)) begin : g_acc_w_check
        $error("ACC_W too narrow to hold N_TERMS products without wrap");
    end
    if (SHIFT < 0 || SHIFT > ACC_W - 4) begin : g_shift_check
        $error("SHIFT out of range 0..ACC_W-4");
    end

    logic [c_cnt_w-1:0]      r_cnt;
    logic signed [ACC_W-1:0] r_acc;
    logic                    r_m_valid;
    logic [CODE_W-1:0]       r_m_code;
    logic                    r_m_sat;

    logic                    w_last;
    logic                    w_s_ready;
    logic                    w_accept;
    logic signed [7:0]       w_prod;
    logic signed [ACC_W-1:0] w_total;
    logic                    w_sat;
    logic [CODE_W-1:0]       w_code;

    assign w_last    = (r_cnt == c_last_cnt);
    // Only the final term waits, and only if the slot stays occupied
    assign w_s_ready = !(w_last && r_m_valid && !m_ready);
    assign w_accept  = s_valid && w_s_ready && !clr;
    assign w_prod    = $signed(x_data) * $signed(w_data);
    assign w_total   = r_acc + ACC_W'(w_prod);

    tanh_4bit_preact_quant #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT)
    ) u_quant (
        .i_sum  (w_total),
        .o_sat  (w_sat),
        .o_code (w_code)
    );

    // Term counter and accumulator; clr aborts the vector, final term restarts it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (clr) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            if (w_last) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else begin
                r_acc <= w_total;
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
        end
    end

    // Output slot: loaded by the final term, emptied by the consumer, untouched by clr
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_valid <= 1'b0;
            r_m_code  <= CODE_ZERO;
            r_m_sat   <= 1'b0;
        end else if (w_accept && w_last) begin
            r_m_valid <= 1'b1;
            r_m_code  <= w_code;
            r_m_sat   <= w_sat;
        end else if (m_ready) begin
            r_m_valid <= 1'b0;
        end
    end

    assign s_ready = w_s_ready;
    assign m_valid = r_m_valid;
    assign m_code  = r_m_code;
    assign m_sat   = r_m_sat;

endmodule
`default_nettype wire

// File: tb/tb_tanh_4bit_preact_mac.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tanh_4bit_preact_mac
//  Description : Self-checking bench for tanh_4bit_preact_mac. Expected codes
//                come from an integer model: sum of products, floor division
//                by 2**SHIFT, clamp to [-8,7], add 8.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tanh_4bit_preact_mac;

    localparam int N_TERMS = 8;
    localparam int ACC_W   = 12;
    localparam int SHIFT   = 4;
    localparam int DIV     = 1 << SHIFT;

    logic       clk;
    logic       rst;
    logic       clr;
    logic       s_valid;
    logic       s_ready;
    logic [3:0] x_data;
    logic [3:0] w_data;
    logic       m_valid;
    logic       m_ready;
    logic [3:0] m_code;
    logic       m_sat;

    int n_cmp = 0;
    int n_err = 0;

    tanh_4bit_preact_mac #(
        .N_TERMS (N_TERMS),
        .ACC_W   (ACC_W),
        .SHIFT   (SHIFT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .x_data  (x_data),
        .w_data  (w_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_code  (m_code),
        .m_sat   (m_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: floor(sum / 2**SHIFT), clamped, offset by 8
    function automatic int ref_q(input int sum);
        if (sum >= 0) return sum / DIV;
        return -((-sum + DIV - 1) / DIV);
    endfunction

    function automatic int ref_code(input int sum);
        int q;
        q = ref_q(sum);
        if (q > 7)  q = 7;
        if (q < -8) q = -8;
        return q + 8;
    endfunction

    function automatic int ref_sat(input int sum);
        int q;
        q = ref_q(sum);
        return (q > 7 || q < -8) ? 1 : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present one pair and hold it until accepted (bounded)
    task automatic beat(input int x, input int w, output int waited);
        waited  = 0;
        s_valid = 1'b1;
        x_data  = 4'(x);
        w_data  = 4'(w);
        while (!s_ready && waited < 40) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!s_ready) check("beat_accept_timeout", {31'd0, s_ready}, 32'd1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        x_data  = 'x;
        w_data  = 'x;
    endtask

    // Full vector with the consumer always ready
    task automatic run_vector(input string tag, input int xs[N_TERMS], input int ws[N_TERMS]);
        int sum;
        int waited;
        sum     = 0;
        m_ready = 1'b1;
        for (int i = 0; i < N_TERMS; i++) begin
            sum += xs[i] * ws[i];
            beat(xs[i], ws[i], waited);
            if (i == N_TERMS - 2) check({tag, "_early_valid"}, {31'd0, m_valid}, 32'd0);
        end
        check({tag, "_valid"}, {31'd0, m_valid}, 32'd1);
        check({tag, "_code"},  {28'd0, m_code},  32'(ref_code(sum)));
        check({tag, "_sat"},   {31'd0, m_sat},   32'(ref_sat(sum)));
        @(posedge clk); #1;
        check({tag, "_drop"},  {31'd0, m_valid}, 32'd0);
    endtask

    initial begin
        int xs[N_TERMS];
        int ws[N_TERMS];
        int waited;

        rst = 1'b1; clr = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
        x_data = 'x; w_data = 'x;
        #3;
        check("reset_m_valid", {31'd0, m_valid}, 32'd0);
        check("reset_m_code",  {28'd0, m_code},  32'd8);
        check("reset_m_sat",   {31'd0, m_sat},   32'd0);
        check("reset_s_ready", {31'd0, s_ready}, 32'd1);
        #9 rst = 1'b0;
        @(posedge clk); #1;

        // Directed sums
        foreach (xs[i]) begin xs[i] = 1; ws[i] = 1; end
        run_vector("ones", xs, ws);
        foreach (xs[i]) begin xs[i] = 7; ws[i] = 7; end
        run_vector("pos_sat", xs, ws);
        foreach (xs[i]) begin xs[i] = -8; ws[i] = 7; end
        run_vector("neg_sat", xs, ws);
        foreach (xs[i]) begin xs[i] = 0; ws[i] = 0; end
        xs[0] = -1; ws[0] = 1;
        run_vector("floor_m1", xs, ws);

        // Randomized vectors
        for (int v = 0; v < 8; v++) begin
            foreach (xs[i]) begin
                xs[i] = int'($urandom_range(0, 15)) - 8;
                ws[i] = int'($urandom_range(0, 15)) - 8;
            end
            run_vector("random", xs, ws);
        end

        // Backpressure: held result A (sum 72 -> 12), vector B (sum 32 -> 10)
        m_ready = 1'b0;
        for (int i = 0; i < N_TERMS; i++) beat(3, 3, waited);
        check("bp_held_valid", {31'd0, m_valid}, 32'd1);
        check("bp_held_code",  {28'd0, m_code},  32'd12);
        for (int i = 0; i < N_TERMS - 1; i++) begin
            beat(2, 2, waited);
            check("bp_nonfinal_stall", 32'(waited), 32'd0);
        end
        s_valid = 1'b1; x_data = 4'd2; w_data = 4'd2;
        repeat (3) @(posedge clk);
        #1;
        check("bp_final_stalled", {31'd0, s_ready}, 32'd0);
        check("bp_still_valid",   {31'd0, m_valid}, 32'd1);
        check("bp_code_stable",   {28'd0, m_code},  32'd12);
        m_ready = 1'b1;
        #1;
        check("bp_passthrough_ready", {31'd0, s_ready}, 32'd1);
        @(posedge clk); #1;
        s_valid = 1'b0; x_data = 'x; w_data = 'x;
        check("bp_refill_valid", {31'd0, m_valid}, 32'd1);
        check("bp_refill_code",  {28'd0, m_code},  32'd10);
        @(posedge clk); #1;
        check("bp_no_duplicate", {31'd0, m_valid}, 32'd0);

        // clr drops the beat it arrives with and restarts the count
        for (int i = 0; i < 4; i++) beat(1, 1, waited);
        s_valid = 1'b1; x_data = 4'd5; w_data = 4'd5; clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0; s_valid = 1'b0; x_data = 'x; w_data = 'x;
        check("clr_no_output", {31'd0, m_valid}, 32'd0);
        foreach (xs[i]) begin xs[i] = 2; ws[i] = 2; end
        run_vector("after_clr", xs, ws);

        // clr leaves a held result alone
        m_ready = 1'b0;
        for (int i = 0; i < N_TERMS; i++) beat(3, 3, waited);
        beat(4, 4, waited);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        check("clr_hold_valid", {31'd0, m_valid}, 32'd1);
        check("clr_hold_code",  {28'd0, m_code},  32'd12);
        m_ready = 1'b1;
        @(posedge clk); #1;
        check("clr_hold_drain", {31'd0, m_valid}, 32'd0);
        foreach (xs[i]) begin xs[i] = -3; ws[i] = 5; end
        run_vector("after_clr_hold", xs, ws);

        // Asynchronous reset mid-vector with a result held
        m_ready = 1'b0;
        for (int i = 0; i < N_TERMS; i++) beat(2, 2, waited);
        for (int i = 0; i < 3; i++) beat(3, 3, waited);
        #2 rst = 1'b1;
        #1;
        check("arst_m_valid", {31'd0, m_valid}, 32'd0);
        check("arst_m_code",  {28'd0, m_code},  32'd8);
        check("arst_m_sat",   {31'd0, m_sat},   32'd0);
        check("arst_s_ready", {31'd0, s_ready}, 32'd1);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        foreach (xs[i]) begin xs[i] = 1; ws[i] = 1; end
        run_vector("after_rst", xs, ws);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
